// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing and a retired-instruction counter.
// Optional MC_CTRL_ILLEGAL_TRAP_EN adds an 'illegal' output and a HALT state for unknown instructions.
module mc_ctrl #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           inst,
    input  logic                  imem_ready,
    input  logic                  dmem_ready,
    input  logic [2:0]            flag,
    output logic                  imem_req,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic [1:0]            npc_op,
    output logic [2:0]            sext_op,
    output logic                  alua_sel,
    output logic                  alub_sel,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic                  rf_we,
    output logic [2:0]            wd_sel,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN/8-1:0]     dmem_be,
    output logic [2:0]            load_ext,
    output logic                  retire,
    output logic [CNT_W-1:0]      instr_cnt
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                  illegal
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t      state_r, state_n;
    logic [31:0] ir_r;
    logic [CNT_W-1:0] cnt_r;

    logic [6:0] opcode_s;
    logic [2:0] f3_s;
    logic [6:0] f7_s;
    logic       legal_s, is_load_s, is_store_s, is_branch_s, is_jal_s, is_jalr_s, is_lui_s;
    logic       alua_s, alub_s;
    logic [2:0] sext_s;
    logic [3:0] alu_s;
    logic       unused_ir_s;

    assign opcode_s    = ir_r[6:0];
    assign f3_s        = ir_r[14:12];
    assign f7_s        = ir_r[31:25];
    assign unused_ir_s = ^{ir_r[24:15], ir_r[11:7]};

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_of = alt ? 4'd1 : 4'd0;
            3'b001:  alu_of = 4'd5;
            3'b010:  alu_of = 4'd8;
            3'b011:  alu_of = 4'd9;
            3'b100:  alu_of = 4'd4;
            3'b101:  alu_of = alt ? 4'd7 : 4'd6;
            3'b110:  alu_of = 4'd3;
            3'b111:  alu_of = 4'd2;
            default: alu_of = 4'd0;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic [2:0] fl);
        case (f3)
            3'b000:  br_taken = fl[1];
            3'b001:  br_taken = ~fl[1];
            3'b100:  br_taken = fl[0];
            3'b101:  br_taken = ~fl[0];
            3'b110:  br_taken = fl[2];
            3'b111:  br_taken = ~fl[2];
            default: br_taken = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   be_of = 4'b0001;
            2'b01:   be_of = 4'b0011;
            2'b10:   be_of = 4'b1111;
            default: be_of = 4'b0000;
        endcase
    endfunction

    // Instruction classification and per-class ALU/immediate selection from the internal IR
    always_comb begin
        legal_s     = 1'b0;
        is_load_s   = 1'b0;
        is_store_s  = 1'b0;
        is_branch_s = 1'b0;
        is_jal_s    = 1'b0;
        is_jalr_s   = 1'b0;
        is_lui_s    = 1'b0;
        alua_s      = 1'b0;
        alub_s      = 1'b0;
        sext_s      = 3'd0;
        alu_s       = 4'd0;
        case (opcode_s)
            OP_R: begin
                alu_s   = alu_of(f3_s, f7_s[5]);
                legal_s = (f7_s == 7'b0000000) ||
                          ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101)));
            end
            OP_I: begin
                alub_s = 1'b1;
                // funct7 only qualifies the shift forms; addi with imm[10] set stays an add
                if (f3_s == 3'b001) begin
                    sext_s  = 3'd5;
                    alu_s   = 4'd5;
                    legal_s = (f7_s == 7'b0000000);
                end else if (f3_s == 3'b101) begin
                    sext_s  = 3'd5;
                    alu_s   = alu_of(f3_s, f7_s[5]);
                    legal_s = (f7_s == 7'b0000000) || (f7_s == 7'b0100000);
                end else begin
                    alu_s   = alu_of(f3_s, 1'b0);
                    legal_s = 1'b1;
                end
            end
            OP_LOAD: begin
                is_load_s = 1'b1;
                alub_s    = 1'b1;
                legal_s   = f3_s inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OP_STORE: begin
                is_store_s = 1'b1;
                alub_s     = 1'b1;
                sext_s     = 3'd1;
                legal_s    = f3_s inside {3'b000, 3'b001, 3'b010};
            end
            OP_BRANCH: begin
                is_branch_s = 1'b1;
                sext_s      = 3'd2;
                alu_s       = 4'd1;
                legal_s     = (f3_s != 3'b010) && (f3_s != 3'b011);
            end
            OP_JAL: begin
                is_jal_s = 1'b1;
                sext_s   = 3'd4;
                legal_s  = 1'b1;
            end
            OP_JALR: begin
                is_jalr_s = 1'b1;
                alub_s    = 1'b1;
                legal_s   = (f3_s == 3'b000);
            end
            OP_LUI: begin
                is_lui_s = 1'b1;
                alub_s   = 1'b1;
                sext_s   = 3'd3;
                legal_s  = 1'b1;
            end
            OP_AUIPC: begin
                alua_s  = 1'b1;
                alub_s  = 1'b1;
                sext_s  = 3'd3;
                legal_s = 1'b1;
            end
            default: legal_s = 1'b0;
        endcase
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_s;
`endif

    // Next-state and control outputs; everything forced low while rst_n is asserted
    always_comb begin
        state_n  = state_r;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        npc_op   = 2'd0;
        sext_op  = 3'd0;
        alua_sel = 1'b0;
        alub_sel = 1'b0;
        alu_op   = '0;
        rf_we    = 1'b0;
        wd_sel   = 3'd0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        dmem_be  = '0;
        load_ext = 3'd0;
        retire   = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        illegal_s = 1'b0;
`endif
        if (!rst_n) begin
            state_n = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we   = 1'b1;
                        state_n = S_DECODE;
                    end else begin
                        state_n = S_FETCH;
                    end
                end
                S_DECODE: begin
                    sext_op = sext_s;
                    if (legal_s) begin
                        state_n = S_EXEC;
                    end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        state_n = S_HALT;
`else
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_n = S_FETCH;
`endif
                    end
                end
                S_EXEC: begin
                    sext_op  = sext_s;
                    alua_sel = alua_s;
                    alub_sel = alub_s;
                    alu_op   = ALU_OP_W'(alu_s);
                    if (is_branch_s) begin
                        pc_we   = 1'b1;
                        npc_op  = br_taken(f3_s, flag) ? 2'd2 : 2'd0;
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end else if (is_load_s || is_store_s) begin
                        state_n = S_MEM;
                    end else begin
                        state_n = S_WB;
                    end
                end
                S_MEM: begin
                    sext_op  = sext_s;
                    alua_sel = alua_s;
                    alub_sel = alub_s;
                    alu_op   = ALU_OP_W'(alu_s);
                    dmem_req = 1'b1;
                    dmem_we  = is_store_s;
                    dmem_be  = be_of(f3_s);
                    load_ext = f3_s;
                    if (!dmem_ready) begin
                        state_n = S_MEM;
                    end else if (is_store_s) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end
                S_WB: begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    if (is_load_s) begin
                        wd_sel = 3'd1;
                    end else if (is_jal_s || is_jalr_s) begin
                        wd_sel = 3'd2;
                    end else if (is_lui_s) begin
                        wd_sel = 3'd3;
                    end else begin
                        wd_sel = 3'd0;
                    end
                    npc_op  = is_jal_s ? 2'd2 : (is_jalr_s ? 2'd1 : 2'd0);
                    state_n = S_FETCH;
                end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                S_HALT: begin
                    illegal_s = 1'b1;
                    state_n   = S_HALT;
                end
`endif
                default: state_n = S_FETCH;
            endcase
        end
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal = illegal_s;
`endif

    assign instr_cnt = rst_n ? cnt_r : '0;

    // State, IR and retired-instruction counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
            ir_r    <= 32'd0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            ir_r    <= ir_we ? inst : ir_r;
            cnt_r   <= cnt_r + CNT_W'(retire);
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected control vectors and counts are queued, then replayed and compared.
module tb_mc_ctrl;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] npc_op;
        logic [2:0] sext_op;
        logic       alua_sel;
        logic       alub_sel;
        logic [3:0] alu_op;
        logic       rf_we;
        logic [2:0] wd_sel;
        logic       dmem_req;
        logic       dmem_we;
        logic [3:0] dmem_be;
        logic [2:0] load_ext;
        logic       retire;
    } ctl_t;

    typedef struct packed {
        logic        rn;
        logic        ir;
        logic        dr;
        logic        ill;
        logic [31:0] cnt;
        ctl_t        c;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = 32'd0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic [2:0]  flag = 3'd0;
    logic        imem_req, ir_we, pc_we, alua_sel, alub_sel, rf_we, dmem_req, dmem_we, retire;
    logic [1:0]  npc_op;
    logic [2:0]  sext_op, wd_sel, load_ext;
    logic [3:0]  alu_op, dmem_be;
    logic [31:0] instr_cnt;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    ctl_t  obs;
    ent_t  sb_q[$];
    string tag_q[$];
    int    tests_run = 0;
    int    tests_failed = 0;
    logic [31:0] m_cnt = 32'd0;

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .flag(flag), .imem_req(imem_req), .ir_we(ir_we),
        .pc_we(pc_we), .npc_op(npc_op), .sext_op(sext_op), .alua_sel(alua_sel),
        .alub_sel(alub_sel), .alu_op(alu_op), .rf_we(rf_we), .wd_sel(wd_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .load_ext(load_ext),
        .retire(retire), .instr_cnt(instr_cnt)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    assign obs = {imem_req, ir_we, pc_we, npc_op, sext_op, alua_sel, alub_sel, alu_op,
                  rf_we, wd_sel, dmem_req, dmem_we, dmem_be, load_ext, retire};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t c_f(input logic irwe);
        ctl_t c = '0;
        c.imem_req = 1'b1;
        c.ir_we    = irwe;
        return c;
    endfunction

    function automatic ctl_t c_d(input logic [2:0] sx, input logic nop);
        ctl_t c = '0;
        c.sext_op = sx;
        c.pc_we   = nop;
        c.retire  = nop;
        return c;
    endfunction

    function automatic ctl_t c_e(input logic [2:0] sx, input logic a, input logic b);
        ctl_t c = '0;
        c.sext_op  = sx;
        c.alua_sel = a;
        c.alub_sel = b;
        return c;
    endfunction

    function automatic ctl_t c_br(input logic [1:0] npc);
        ctl_t c = '0;
        c.sext_op = 3'd2;
        c.alu_op  = 4'd1;
        c.pc_we   = 1'b1;
        c.npc_op  = npc;
        c.retire  = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_m(input logic [2:0] sx, input logic we, input logic [3:0] be,
                                 input logic [2:0] lext, input logic done);
        ctl_t c = '0;
        c.sext_op  = sx;
        c.alub_sel = 1'b1;
        c.dmem_req = 1'b1;
        c.dmem_we  = we;
        c.dmem_be  = be;
        c.load_ext = lext;
        c.pc_we    = done & we;
        c.retire   = done & we;
        return c;
    endfunction

    function automatic ctl_t c_wb(input logic [2:0] wd, input logic [1:0] npc);
        ctl_t c = '0;
        c.rf_we  = 1'b1;
        c.pc_we  = 1'b1;
        c.retire = 1'b1;
        c.wd_sel = wd;
        c.npc_op = npc;
        return c;
    endfunction

    task automatic push(input string tag, input logic rn, input logic ir, input logic dr,
                        input ctl_t c, input logic ill);
        ent_t e;
        if (!rn) m_cnt = 32'd0;
        e.rn  = rn;
        e.ir  = ir;
        e.dr  = dr;
        e.ill = ill;
        e.cnt = m_cnt;
        e.c   = c;
        if (rn && c.retire) m_cnt = m_cnt + 32'd1;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Replays queued stimulus one cycle per entry and compares on the falling edge
    task automatic drain();
        ent_t  e;
        string t;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            rst_n      = e.rn;
            imem_ready = e.ir;
            dmem_ready = e.dr;
            @(negedge clk);
            check_eq({t, ".ctl"}, {4'd0, obs}, {4'd0, e.c});
            check_eq({t, ".cnt"}, instr_cnt, e.cnt);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            check_eq({t, ".ill"}, {31'd0, illegal}, {31'd0, e.ill});
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_branch(input string tag, input logic [31:0] ins, input logic [2:0] fl,
                              input logic [1:0] npc);
        inst = ins;
        flag = fl;
        push({tag, ".F"}, 1'b1, 1'b1, 1'b0, c_f(1'b1), 1'b0);
        push({tag, ".D"}, 1'b1, 1'b0, 1'b0, c_d(3'd2, 1'b0), 1'b0);
        push({tag, ".E"}, 1'b1, 1'b0, 1'b0, c_br(npc), 1'b0);
        drain();
    endtask

    initial begin
        @(posedge clk);
        #1;
        inst = 32'h002081B3;
        push("rst", 1'b0, 1'b1, 1'b0, '0, 1'b0);
        drain();

        // add x3,x1,x2
        push("add.F", 1'b1, 1'b1, 1'b0, c_f(1'b1), 1'b0);
        push("add.D", 1'b1, 1'b0, 1'b0, c_d(3'd0, 1'b0), 1'b0);
        push("add.E", 1'b1, 1'b0, 1'b0, c_e(3'd0, 1'b0, 1'b0), 1'b0);
        push("add.W", 1'b1, 1'b0, 1'b0, c_wb(3'd0, 2'd0), 1'b0);
        drain();

        run_branch("beq_t",  32'h00208063, 3'b010, 2'd2);
        run_branch("beq_nt", 32'h00208063, 3'b000, 2'd0);
        run_branch("bgeu",   32'h0020F063, 3'b100, 2'd0);
        run_branch("bltu",   32'h0020E063, 3'b100, 2'd2);
        flag = 3'd0;

        // lh x5,4(x1): one imem wait, three dmem waits
        inst = 32'h00409283;
        push("lh.Fw", 1'b1, 1'b0, 1'b0, c_f(1'b0), 1'b0);
        push("lh.F",  1'b1, 1'b1, 1'b0, c_f(1'b1), 1'b0);
        push("lh.D",  1'b1, 1'b0, 1'b0, c_d(3'd0, 1'b0), 1'b0);
        push("lh.E",  1'b1, 1'b0, 1'b0, c_e(3'd0, 1'b0, 1'b1), 1'b0);
        for (int i = 0; i < 4; i++)
            push("lh.M", 1'b1, 1'b0, (i == 3), c_m(3'd0, 1'b0, 4'b0011, 3'b001, (i == 3)), 1'b0);
        push("lh.W",  1'b1, 1'b0, 1'b0, c_wb(3'd1, 2'd0), 1'b0);
        drain();

        // sb x2,0(x1)
        inst = 32'h00208023;
        push("sb.F", 1'b1, 1'b1, 1'b0, c_f(1'b1), 1'b0);
        push("sb.D", 1'b1, 1'b0, 1'b0, c_d(3'd1, 1'b0), 1'b0);
        push("sb.E", 1'b1, 1'b0, 1'b0, c_e(3'd1, 1'b0, 1'b1), 1'b0);
        push("sb.M", 1'b1, 1'b0, 1'b1, c_m(3'd1, 1'b1, 4'b0001, 3'b000, 1'b1), 1'b0);
        drain();

        // jalr x1,0(x2)
        inst = 32'h000100E7;
        push("jalr.F", 1'b1, 1'b1, 1'b0, c_f(1'b1), 1'b0);
        push("jalr.D", 1'b1, 1'b0, 1'b0, c_d(3'd0, 1'b0), 1'b0);
        push("jalr.E", 1'b1, 1'b0, 1'b0, c_e(3'd0, 1'b0, 1'b1), 1'b0);
        push("jalr.W", 1'b1, 1'b0, 1'b0, c_wb(3'd2, 2'd1), 1'b0);
        drain();

        // auipc x1,1
        inst = 32'h00001097;
        push("auipc.F", 1'b1, 1'b1, 1'b0, c_f(1'b1), 1'b0);
        push("auipc.D", 1'b1, 1'b0, 1'b0, c_d(3'd3, 1'b0), 1'b0);
        push("auipc.E", 1'b1, 1'b0, 1'b0, c_e(3'd3, 1'b1, 1'b1), 1'b0);
        push("auipc.W", 1'b1, 1'b0, 1'b0, c_wb(3'd0, 2'd0), 1'b0);
        drain();

`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        // unknown opcode and unknown funct7 retire as NOPs from DECODE
        inst = 32'h0000007F;
        push("nop_op.F", 1'b1, 1'b1, 1'b0, c_f(1'b1), 1'b0);
        push("nop_op.D", 1'b1, 1'b0, 1'b0, c_d(3'd0, 1'b1), 1'b0);
        drain();
        inst = 32'h022081B3;
        push("nop_f7.F", 1'b1, 1'b1, 1'b0, c_f(1'b1), 1'b0);
        push("nop_f7.D", 1'b1, 1'b0, 1'b0, c_d(3'd0, 1'b1), 1'b0);
        drain();
`endif

        // sw x2,0(x1) stalled in MEM, then reset
        inst = 32'h0020A023;
        push("sw.F",  1'b1, 1'b1, 1'b0, c_f(1'b1), 1'b0);
        push("sw.D",  1'b1, 1'b0, 1'b0, c_d(3'd1, 1'b0), 1'b0);
        push("sw.E",  1'b1, 1'b0, 1'b0, c_e(3'd1, 1'b0, 1'b1), 1'b0);
        push("sw.M",  1'b1, 1'b0, 1'b0, c_m(3'd1, 1'b1, 4'b1111, 3'b010, 1'b0), 1'b0);
        push("sw.R0", 1'b0, 1'b0, 1'b0, '0, 1'b0);
        push("sw.R1", 1'b0, 1'b0, 1'b0, '0, 1'b0);
        push("sw.Fw", 1'b1, 1'b0, 1'b0, c_f(1'b0), 1'b0);
        drain();

        inst = 32'h002081B3;
        push("add2.F",  1'b1, 1'b1, 1'b0, c_f(1'b1), 1'b0);
        push("add2.D",  1'b1, 1'b0, 1'b0, c_d(3'd0, 1'b0), 1'b0);
        push("add2.E",  1'b1, 1'b0, 1'b0, c_e(3'd0, 1'b0, 1'b0), 1'b0);
        push("add2.W",  1'b1, 1'b0, 1'b0, c_wb(3'd0, 2'd0), 1'b0);
        push("add2.Fw", 1'b1, 1'b0, 1'b0, c_f(1'b0), 1'b0);
        drain();

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        // unknown opcode halts with illegal set and the counter frozen
        inst = 32'h0000007F;
        push("halt.F", 1'b1, 1'b1, 1'b0, c_f(1'b1), 1'b0);
        push("halt.D", 1'b1, 1'b0, 1'b0, c_d(3'd0, 1'b0), 1'b0);
        for (int i = 0; i < 4; i++)
            push("halt.H", 1'b1, 1'b1, 1'b1, '0, 1'b1);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
